fetch_stage: RTL and testbench

Fetch stage of the 16-bit single-issue core. It holds the architectural PC and fetches one instruction per PC from instruction memory using a req/ack handshake. It presents the instruction to decode with a valid/ready handshake. It exports the current PC to the next-PC logic and loads that logic's result when decode accepts the instruction.

---
 rtl/fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Fetch stage of the 16-bit single-issue core. Holds the architectural PC,
// reads one instruction per PC from instruction memory over a req/ack
// handshake and hands it to decode over a valid/ready handshake. On a
// non-HALT accept the PC is loaded from the external next-PC logic. A
// redirect (flush) restarts fetch at redirect_pc.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, adds the fetch_count and stall_count performance counters.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   next_pc        next PC from the next-PC logic (computed from pc_out)
//   pc_out         PC of the instruction being fetched or held
//   imem_req       instruction-memory read request
//   imem_addr      read address of the outstanding request
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     instruction word from memory
//   instr_out      registered instruction to decode
//   instr_valid    instr_out is valid
//   instr_ready    decode accepts instr_out
//   halt_in        decode flags instr_out as HALT
//   redirect_valid flush current fetch, restart at redirect_pc
//   redirect_pc    restart address
//   halted         core has stopped fetching
//   fetch_count    (FETCH_PERF_CNT_EN) accepted instructions, wraps at 2^32
//   stall_count    (FETCH_PERF_CNT_EN) stall cycles, wraps at 2^32
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              halt_in,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    // Address of the request currently on the bus. It differs from pc_reg
    // only while a redirected request is still waiting for its stale ack.
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       instr_reg;
    logic              valid_reg;
    logic              req_reg;
    logic              halted_reg;
    // Set when the outstanding request belongs to a PC that was flushed;
    // its returning data must be thrown away.
    logic              discard_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RESET;
            pc_reg      <= RESET_PC;
            addr_reg    <= RESET_PC;
            instr_reg   <= '0;
            valid_reg   <= 1'b0;
            req_reg     <= 1'b0;
            halted_reg  <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    state_reg <= ST_REQ;
                    req_reg   <= 1'b1;
                    addr_reg  <= pc_reg;
                end

                ST_REQ: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        valid_reg <= 1'b0;
                        if (imem_ack) begin
                            // The returning word is stale; reissue at the
                            // redirect target next cycle.
                            discard_reg <= 1'b0;
                            addr_reg    <= redirect_pc;
                        end else begin
                            // Keep the old request on the bus until its ack.
                            discard_reg <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (discard_reg) begin
                            discard_reg <= 1'b0;
                            addr_reg    <= pc_reg;
                        end else begin
                            instr_reg <= imem_rdata;
                            valid_reg <= 1'b1;
                            req_reg   <= 1'b0;
                            state_reg <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        addr_reg  <= redirect_pc;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= ST_REQ;
                    end else if (instr_ready) begin
                        valid_reg <= 1'b0;
                        if (halt_in) begin
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALTED;
                        end else begin
                            pc_reg    <= next_pc;
                            addr_reg  <= next_pc;
                            req_reg   <= 1'b1;
                            state_reg <= ST_REQ;
                        end
                    end
                end

                ST_HALTED: begin
                    // Only reset leaves this state.
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end

                default: begin
                    state_reg <= ST_RESET;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = pc_reg;
    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign instr_out   = instr_reg;
    assign instr_valid = valid_reg;
    assign halted      = halted_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;
    logic        accept;
    logic        stall;

    // A redirect in HOLD takes priority, so that cycle is not an accept.
    assign accept = (state_reg == ST_HOLD) && instr_ready && !redirect_valid;
    assign stall  = ((state_reg == ST_REQ) && !imem_ack) ||
                    ((state_reg == ST_HOLD) && !instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            if (accept) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (stall) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A memory model answers requests after
// a programmable delay and pushes the expected {pc, word} onto a scoreboard
// queue for every word that decode should see; a monitor pops and compares
// on the decode side. Directed checks cover reset, latency, backpressure,
// redirect, HALT and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] next_pc;
    logic [15:0] pc_out;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        halt_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .pc_out         (pc_out),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .halt_in        (halt_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    // Sequential next-PC logic.
    assign next_pc = pc_out + 16'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   mem_delay;
    int   wait_cnt;
    logic expect_drop;
    logic [15:0] req_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: reacts 2 time units after each rising edge.
    initial begin
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        wait_cnt    = 0;
        req_addr    = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (imem_ack) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
            if (rst_n && imem_req) begin
                if (wait_cnt == 0) begin
                    req_addr = imem_addr;
                end else begin
                    check("addr_stable", imem_addr, req_addr);
                end
                if (wait_cnt >= mem_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    if (expect_drop) begin
                        expect_drop = 1'b0;
                    end else begin
                        exp_q.push_back({imem_addr, mem_word(imem_addr)});
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Decode-side monitor: every valid word must be the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            check("valid_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_instr", instr_out, exp_q[0].data);
                if (instr_ready && !redirect_valid) begin
                    check("sb_pc", pc_out, exp_q[0].pc);
                    $display("accept pc=%h instr=%h", pc_out, instr_out);
                end
                if (instr_ready || redirect_valid) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec          = 0;
        n_err          = 0;
        mem_delay      = 0;
        expect_drop    = 1'b0;
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        halt_in        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset state
        repeat (3) tick();
        check("rst_pc", pc_out, 16'h0000);
        check("rst_instr", instr_out, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_halted", halted, 1'b0);

        // Zero-wait fetch
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        check("req_in_reset_cycle", imem_req, 1'b0);
        tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 16'h0000);
        tick();
        check("first_valid", instr_valid, 1'b1);
        check("first_instr", instr_out, 16'h1234);
        mem_delay = 2;
        tick();
        check("pc_after_hs", pc_out, 16'h0001);
        check("valid_after_hs", instr_valid, 1'b0);

        // 3-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            check("slow_req", imem_req, 1'b1);
            check("slow_addr", imem_addr, 16'h0001);
            check("slow_valid", instr_valid, 1'b0);
            if (i == 2) instr_ready = 1'b0;
            tick();
        end
        check("slow_valid_rise", instr_valid, 1'b1);
        check("slow_req_drop", imem_req, 1'b0);

        // Backpressure for 4 cycles
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", instr_valid, 1'b1);
            check("bp_instr", instr_out, mem_word(16'h0001));
            check("bp_pc", pc_out, 16'h0001);
            check("bp_req", imem_req, 1'b0);
            tick();
        end
        check("bp_valid_5th", instr_valid, 1'b1);
        instr_ready = 1'b1;
        tick();
        check("bp_pc_after", pc_out, 16'h0002);
        check("bp_valid_after", instr_valid, 1'b0);

        // Redirect while the request is still pending
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        expect_drop    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("rd_pc", pc_out, 16'h0040);
        check("rd_addr_old", imem_addr, 16'h0002);
        check("rd_req", imem_req, 1'b1);
        check("rd_valid", instr_valid, 1'b0);
        tick();
        check("rd_addr_old2", imem_addr, 16'h0002);
        check("rd_valid2", instr_valid, 1'b0);
        mem_delay = 0;
        tick();
        check("rd_addr_new", imem_addr, 16'h0040);
        check("rd_req_new", imem_req, 1'b1);
        check("rd_valid3", instr_valid, 1'b0);
        instr_ready = 1'b0;
        tick();
        check("rd_new_valid", instr_valid, 1'b1);
        check("rd_new_instr", instr_out, mem_word(16'h0040));

        // Redirect while holding, to the HALT location
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        check("hold_rd_valid", instr_valid, 1'b0);
        check("hold_rd_pc", pc_out, 16'h0010);
        check("hold_rd_addr", imem_addr, 16'h0010);
        tick();
        check("halt_word_valid", instr_valid, 1'b1);

        // HALT: ignored without handshake, then taken
        halt_in = 1'b1;
        tick();
        check("halt_no_hs", halted, 1'b0);
        check("halt_no_hs_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        tick();
        halt_in = 1'b0;
        check("halted", halted, 1'b1);
        check("halted_valid", instr_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i >= 3 && i < 6);
            redirect_pc    = 16'h0055;
            check("halted_req", imem_req, 1'b0);
            check("halted_pc", pc_out, 16'h0010);
            check("halted_flag", halted, 1'b1);
            tick();
        end
        redirect_valid = 1'b0;

        // Asynchronous reset from HALTED and mid-request
        rst_n = 1'b0;
        #1;
        check("arst_halted", halted, 1'b0);
        check("arst_pc", pc_out, 16'h0000);
        tick();
        rst_n     = 1'b1;
        mem_delay = 3;
        tick();
        check("arst_req", imem_req, 1'b1);
        tick();
        check("arst_req_wait", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreq_req", imem_req, 1'b0);
        check("midreq_pc", pc_out, 16'h0000);
        check("midreq_valid", instr_valid, 1'b0);
        check("midreq_instr", instr_out, 16'h0000);
        tick();
        rst_n     = 1'b1;
        mem_delay = 0;
        check("restart_req_reset", imem_req, 1'b0);
        tick();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, 16'h0000);
        tick();
        check("restart_valid", instr_valid, 1'b1);
        check("restart_instr", instr_out, 16'h1234);
        tick();
        check("restart_pc", pc_out, 16'h0001);
        instr_ready = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
